serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing a - b - bin
// over WIDTH cycles using a single full-subtractor cell.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] dsh_q;     // difference bits produced so far, newest at top
   logic [WIDTH-1:0] d_q;
   logic             br_q;
   logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   logic             accept_s;
   logic             last_s;
   logic             diff_s;
   logic             br_next_s;
   logic [WIDTH-1:0] dsh_full_s;

   // Full-subtractor cell on the current LSBs plus start-acceptance decode.
   always_comb begin
      accept_s   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      last_s     = (cnt_q == CNT_LAST);
      diff_s     = a_q[0] ^ b_q[0] ^ br_q;
      br_next_s  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      dsh_full_s = {diff_s, dsh_q};
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE chains straight into RUN when start is held.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_d = ST_DONE;
            else        state_d = ST_RUN;
         end
         ST_DONE: begin
            if (accept_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register and result registers.
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
      d    = d_q;
      bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf  = ovf_q;
`endif
   end

   // Operand shifters, borrow chain, bit counter and held result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         dsh_q  <= '0;
         d_q    <= '0;
         br_q   <= 1'b0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else if (accept_s) begin
         a_q   <= a;
         b_q   <= b;
         br_q  <= bin;
         cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         a_q   <= {1'b0, a_q[WIDTH-1:1]};
         b_q   <= {1'b0, b_q[WIDTH-1:1]};
         br_q  <= br_next_s;
         cnt_q <= cnt_q + CNT_ONE;
         dsh_q <= dsh_full_s[WIDTH-1:1];
         if (last_s) begin
            // MSB cycle: br_q is the borrow into the MSB, br_next_s the borrow out.
            d_q    <= dsh_full_s;
            bout_q <= br_next_s;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= br_q ^ br_next_s;
`endif
         end else begin
            d_q    <= d_q;
            bout_q <= bout_q;
         end
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule
